lzd_u0: RTL and testbench

- Pipelined leading-zero detector for the 48-bit uniform sample u0 in the AWGN Box-Muller logarithm path.
- Sits directly upstream of the u0 shifter. Produces exp_e = (leading-zero count of u0) + 1.
- Also emits u0 delayed to align with exp_e, so the shifter consumes the matched pair {u0, exp_e}. The shift strips the leading zeros and the leading one, normalising u0 for log range reduction.
- Fixed 2-cycle latency with a valid-tag pipeline and a global stall.

---
 rtl/lzd_u0.sv | 101 ++++++++++
 tb/tb_lzd_u0.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lzd_u0.sv
// Purpose: two-stage leading-zero detector for the 48-bit Box-Muller sample u0.
//          It produces exp_e = lzc + 1 and the matching delayed u0 for the shifter.
// Latency: 2 advancing cycles (en=1) from in_valid/u0_in to out_valid/exp_e, 1 sample per cycle.
// Backpressure: global stall; en=0 freezes every register, including out_valid.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset (has priority over en)
//   en              pipeline advance
//   in_valid, u0_in new sample tag and data (u0_in is captured on every advancing edge)
//   out_valid       tags u0_out/exp_e/u0_zero
//   u0_out          u0_in delayed to align with exp_e
//   exp_e           leading-zero count + 1 (1..48), or 49 when u0 is zero
//   u0_zero         u0_out == 0
module lzd_u0 #(
    parameter int W  = 48,   // the 6 x 8-bit segment split below assumes exactly 48
    parameter int EW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          in_valid,
    input  logic [W-1:0]  u0_in,
    output logic          out_valid,
    output logic [W-1:0]  u0_out,
    output logic [EW-1:0] exp_e,
    output logic          u0_zero
);

    localparam int NSEG = 6;
    localparam int SW   = 8;

    // Stage 1 combinational: per-segment leading-zero count and all-zero flag
    logic [NSEG-1:0][3:0] seg_lz;
    logic [NSEG-1:0]      seg_zf;

    always_comb begin
        logic [SW-1:0] seg;
        seg    = '0;
        seg_lz = '0;
        seg_zf = '0;
        for (int s = 0; s < NSEG; s++) begin
            seg       = u0_in[s*SW +: SW];
            seg_lz[s] = 4'd8;
            // Ascending scan: the highest set bit is visited last and wins.
            for (int b = 0; b < SW; b++) begin
                if (seg[b]) begin
                    seg_lz[s] = 4'(SW - 1 - b);
                end
            end
            seg_zf[s] = (seg == '0);
        end
    end

    // Stage 1 registers
    logic                 s1_valid;
    logic [W-1:0]         s1_u0;
    logic [NSEG-1:0][3:0] s1_lz;
    logic [NSEG-1:0]      s1_zf;

    // Stage 2 combinational: pick the most significant non-zero segment
    logic [EW-1:0] lzc;
    logic          all_zero;
    logic [EW-1:0] exp_next;

    always_comb begin
        lzc      = EW'(W);
        all_zero = 1'b1;
        // Ascending scan over segments: the most significant non-zero one wins.
        for (int k = 0; k < NSEG; k++) begin
            if (!s1_zf[k]) begin
                lzc      = EW'(SW * (NSEG - 1 - k)) + EW'(s1_lz[k]);
                all_zero = 1'b0;
            end
        end
        // All-zero input gives lzc = 48, hence exp_e = 49 (pass-through code).
        exp_next = lzc + EW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_u0     <= '0;
            s1_lz     <= '0;
            s1_zf     <= '0;
            out_valid <= 1'b0;
            u0_out    <= '0;
            exp_e     <= '0;
            u0_zero   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_u0     <= u0_in;
            s1_lz     <= seg_lz;
            s1_zf     <= seg_zf;
            out_valid <= s1_valid;
            u0_out    <= s1_u0;
            exp_e     <= exp_next;
            u0_zero   <= all_zero;
        end
    end

endmodule

// File: tb/tb_lzd_u0.sv
// Purpose: randomized plus directed bench for lzd_u0 against a behavioural reference.
// Latency: reference holds the last two advanced samples; output = the older one.
// Backpressure: en is toggled randomly; stalled cycles must hold every output.
module tb_lzd_u0;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic [47:0] u0_in;
    logic        out_valid;
    logic [47:0] u0_out;
    logic [5:0]  exp_e;
    logic        u0_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lzd_u0 dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .u0_in     (u0_in),
        .out_valid (out_valid),
        .u0_out    (u0_out),
        .exp_e     (exp_e),
        .u0_zero   (u0_zero)
    );

    // Reference: leading-zero count by a plain bit scan from the MSB.
    function automatic int lzc_ref(input logic [47:0] x);
        int n;
        logic found;
        n = 48;
        found = 1'b0;
        for (int b = 47; b >= 0; b--) begin
            if (!found && x[b]) begin
                n = 47 - b;
                found = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural history: samples accepted on advancing edges since the last reset.
    typedef struct packed {
        logic        v;
        logic [47:0] d;
    } smp_t;

    smp_t hist[$];
    logic known = 1'b0;

    always @(posedge clk) begin
        smp_t s;
        if (reset === 1'b1) begin
            hist.delete();
            known = 1'b1;
        end else if (en === 1'b1) begin
            s.v = in_valid;
            s.d = u0_in;
            hist.push_back(s);
            if (hist.size() > 2) void'(hist.pop_front());
        end
    end

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        logic [47:0] x;
        int lz, p;
        logic nb;
        if (known) begin
            if (hist.size() == 0) begin
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_u0_out",    64'(u0_out),    64'd0);
                chk("rst_exp_e",     64'(exp_e),     64'd0);
                chk("rst_u0_zero",   64'(u0_zero),   64'd0);
            end else if (hist.size() == 1) begin
                chk("out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("out_valid", 64'(out_valid), 64'(hist[0].v));
                if (hist[0].v) begin
                    lz = lzc_ref(hist[0].d);
                    chk("u0_out",  64'(u0_out),  64'(hist[0].d));
                    chk("exp_e",   64'(exp_e),   64'(lz + 1));
                    chk("u0_zero", 64'(u0_zero), 64'(hist[0].d == 48'd0));
                    if (lz < 48) begin
                        // Downstream shifter: bit 47 must be the bit after the leading one.
                        x  = u0_out << exp_e;
                        p  = 47 - lz;
                        nb = (p > 0) ? hist[0].d[p-1] : 1'b0;
                        chk("shift_bit47", 64'(x[47]), 64'(nb));
                    end
                end
            end
        end
    end

    task automatic drive(input logic e, input logic v, input logic [47:0] d);
        en       = e;
        in_valid = v;
        u0_in    = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rand48();
        return {16'($urandom()), $urandom()};
    endfunction

    logic [47:0] lit_u [6] = '{48'h000000000000, 48'hFFFFFFFFFFFF, 48'h00FF00000000,
                               48'h000000000080, 48'h800000000000, 48'h000000000001};
    logic [5:0]  lit_e [6] = '{6'd49, 6'd1, 6'd9, 6'd41, 6'd1, 6'd48};
    logic        lit_z [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        logic [47:0] one;
        logic [47:0] r;
        int bub[5];
        one = 48'd1;
        bub = '{1, 0, 1, 1, 0};

        reset = 1'b1;
        en = 1'b1;
        in_valid = 1'b0;
        u0_in = '0;
        drive(1'b1, 1'b0, 48'd0);
        drive(1'b1, 1'b0, 48'd0);
        reset = 1'b0;

        // Pin the reference and the DUT against hand-computed values.
        for (int i = 0; i < 6; i++) begin
            chk("ref_pin", 64'(lzc_ref(lit_u[i]) + 1), 64'(lit_e[i]));
            drive(1'b1, 1'b1, lit_u[i]);
            drive(1'b1, 1'b0, 48'd0);
            @(negedge clk);
            chk("lit_exp_e",   64'(exp_e),   64'(lit_e[i]));
            chk("lit_u0_zero", 64'(u0_zero), 64'(lit_z[i]));
            @(posedge clk);
            #1;
        end

        // Single-bit sweep, back to back.
        for (int i = 47; i >= 0; i--) begin
            chk("sweep_ref", 64'(lzc_ref(one << i) + 1), 64'(48 - i));
            drive(1'b1, 1'b1, one << i);
        end
        drive(1'b1, 1'b0, 48'd0);
        drive(1'b1, 1'b0, 48'd0);

        // Reset mid-stream.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, rand48());
        reset = 1'b1;
        drive(1'b1, 1'b1, rand48());
        reset = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, rand48());
        drive(1'b1, 1'b0, 48'd0);
        drive(1'b1, 1'b0, 48'd0);

        // Stall hold: 5 samples with a 3-cycle en=0 gap, input held meanwhile.
        for (int i = 0; i < 5; i++) begin
            r = rand48();
            if (i == 2) begin
                for (int s = 0; s < 3; s++) drive(1'b0, 1'b1, r);
            end
            drive(1'b1, 1'b1, r);
        end
        for (int s = 0; s < 3; s++) drive(1'b0, 1'b0, 48'd0);
        drive(1'b1, 1'b0, 48'd0);
        drive(1'b1, 1'b0, 48'd0);

        // Bubbles.
        for (int i = 0; i < 5; i++) drive(1'b1, bub[i] != 0, rand48());
        drive(1'b1, 1'b0, 48'd0);
        drive(1'b1, 1'b0, 48'd0);

        // Random: ~10% with 20+ leading zeros, random stalls, bubbles, rare resets.
        for (int i = 0; i < 10000; i++) begin
            r = rand48();
            if ($urandom_range(0, 9) == 0) r = r >> $urandom_range(20, 48);
            reset = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, r);
        end
        reset = 1'b0;
        drive(1'b1, 1'b0, 48'd0);
        drive(1'b1, 1'b0, 48'd0);
        drive(1'b1, 1'b0, 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
